// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: handshake and operand/result bundle for the sequential
// Booth multiplier.
//   start        - request, sampled by the multiplier only while idle
//   multiplicand - signed operand M, captured on an accepted start
//   multiplier   - signed operand Q, captured on an accepted start
//   busy         - multiplier is iterating
//   done         - one-cycle pulse, product is valid
//   product      - signed M*Q, 2*WIDTH bits, held until the next accepted start
// master: the requester side. slave: the multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier for signed
// two's-complement operands. One Booth iteration per clock. From the start
// edge, busy is high for WIDTH cycles, then done pulses for one cycle
// together with the new product, then the unit is idle again.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset. Aborts any operation in flight.
//   bus  - booth_mul_seq_if.slave carrying start/operands in and
//          busy/done/product out. All outputs are registered.
module booth_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  booth_mul_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One Booth step. It returns the arithmetic right shift of {T, Q, q_m1}
  // packed as {A_next, Q_next, q_m1_next}.
  // The subtract step uses ~Mx+1. Mx is one bit wider than the operand, so
  // negating the most negative operand cannot overflow.
  function automatic logic [2*WIDTH+1:0] booth_step(
    input logic [WIDTH:0]   a,
    input logic [WIDTH-1:0] q,
    input logic             q_m1,
    input logic [WIDTH:0]   mx
  );
    logic [WIDTH:0] t;
    case ({q[0], q_m1})
      2'b00:   t = a;
      2'b11:   t = a;
      2'b01:   t = a + mx;
      2'b10:   t = a + (~mx + {{WIDTH{1'b0}}, 1'b1});
      default: t = a;
    endcase
    booth_step = {t[WIDTH], t, q};
  endfunction

  logic [1:0]         state_r;
  logic [WIDTH:0]     a_r;
  logic [WIDTH-1:0]   q_r;
  logic               q_m1_r;
  logic [WIDTH:0]     mx_r;
  logic [CW-1:0]      count_r;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;
  logic [2*WIDTH+1:0] step_s;

  // Result of the current Booth iteration, computed from the working registers.
  always_comb begin
    step_s = booth_step(a_r, q_r, q_m1_r, mx_r);
  end

  // Control sequence plus the datapath registers. Every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      q_r       <= '0;
      q_m1_r    <= 1'b0;
      mx_r      <= '0;
      count_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= '0;
            q_r     <= bus.multiplier;
            q_m1_r  <= 1'b0;
            mx_r    <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            count_r <= CW'(WIDTH);
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= step_s[2*WIDTH+1:WIDTH+1];
          q_r     <= step_s[WIDTH:1];
          q_m1_r  <= step_s[0];
          count_r <= count_r - CW'(1);
          if (count_r == CW'(1)) begin
            // This is the last iteration. The product is formed from the
            // post-shift {A[WIDTH-1:0], Q}.
            product_r <= step_s[2*WIDTH:1];
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= DONE;
          end else begin
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= RUN;
          end
        end
        DONE: begin
          // Any start seen here is ignored. The unit returns to idle first.
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: self-checking bench for booth_mul_seq (WIDTH = 4).
// A timeline model predicts busy/done/product for every cycle, using signed
// integer multiplication. Directed vectors with literal results pin the model.
module tb_booth_mul_seq;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  booth_mul_seq_if #(.WIDTH(W)) bus ();

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] q);
    int a;
    int b;
    a = int'($signed(m));
    b = int'($signed(q));
    return 8'(a * b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Timeline model. edge_no is the index of the next clock edge. acc_edge is
  // the edge at which the current operation was accepted. free_edge is the
  // first edge at which a new start can be accepted.
  int         edge_no;
  int         acc_edge;
  int         free_edge;
  logic [7:0] pend_prod;
  logic [7:0] exp_product;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_no     <= 0;
      acc_edge    <= -100;
      free_edge   <= 0;
      pend_prod   <= 8'h00;
      exp_product <= 8'h00;
    end else begin
      edge_no <= edge_no + 1;
      if (bus.start === 1'b1 && edge_no >= free_edge) begin
        acc_edge  <= edge_no;
        free_edge <= edge_no + W + 2;
        pend_prod <= ref_mul(bus.multiplicand, bus.multiplier);
      end
      if (edge_no == acc_edge + W) exp_product <= pend_prod;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    int last;
    last = edge_no - 1;
    chk("cmp_busy", {31'd0, bus.busy}, {31'd0, (last >= acc_edge && last < acc_edge + W)});
    chk("cmp_done", {31'd0, bus.done}, {31'd0, (last == acc_edge + W)});
    chk("cmp_product", {24'd0, bus.product}, {24'd0, exp_product});
  end

  task automatic do_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                       input bit scramble, input string tag);
    int lat;
    int bcnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = m;
    bus.multiplier = q;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) bcnt++;
      if (scramble) begin
        bus.multiplicand = 4'($urandom);
        bus.multiplier = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_busy_cycles"}, bcnt, 4);
    chk({tag, "_product"}, {24'd0, bus.product}, {24'd0, exp});
  endtask

  initial begin
    int dn[$];
    int guard;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = 4'h0;
    bus.multiplier = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_product", {24'd0, bus.product}, 32'd0);
    rst = 1'b0;

    // Basic case and sign combinations, with literal products.
    do_op(4'h3, 4'h5, 8'h0F, 1'b0, "basic_3x5");
    do_op(4'h8, 4'h8, 8'h40, 1'b0, "m8xm8");
    do_op(4'h7, 4'h8, 8'hC8, 1'b0, "7xm8");
    do_op(4'hF, 4'hF, 8'h01, 1'b0, "m1xm1");
    do_op(4'h8, 4'h1, 8'hF8, 1'b0, "m8x1");
    do_op(4'h0, 4'h0, 8'h00, 1'b0, "0x0");

    // Exhaustive sweep of all operand pairs.
    for (int m = 0; m < 16; m++) begin
      for (int q = 0; q < 16; q++) begin
        do_op(4'(m), 4'(q), ref_mul(4'(m), 4'(q)), 1'b0, "exh");
      end
    end

    // A start pulsed during RUN and during DONE is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'h3; bus.multiplier = 4'h5;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.multiplicand = 4'h7; bus.multiplier = 4'h7;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("proto_done", {31'd0, bus.done}, 32'd1);
    chk("proto_product", {24'd0, bus.product}, 32'h0F);
    bus.start = 1'b1; bus.multiplicand = 4'hF; bus.multiplier = 4'h2;
    @(negedge clk); bus.start = 1'b0;
    chk("proto_done_ignored_a", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("proto_done_ignored_b", {31'd0, bus.busy}, 32'd0);
    chk("proto_product_held", {24'd0, bus.product}, 32'h0F);

    // With start held high, done pulses every 6 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'hF; bus.multiplier = 4'hF;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dn.push_back(i);
        chk("held_product", {24'd0, bus.product}, 32'h01);
      end
    end
    bus.start = 1'b0;
    chk("held_done_count", dn.size(), 3);
    if (dn.size() >= 3) begin
      chk("held_period_a", dn[1] - dn[0], 6);
      chk("held_period_b", dn[2] - dn[1], 6);
    end
    guard = 0;
    while ((bus.busy === 1'b1 || bus.done === 1'b1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("held_drain_timeout", {31'd0, guard >= 20}, 32'd0);

    // An asynchronous reset during the second RUN iteration aborts the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'h3; bus.multiplier = 4'h5;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_product", {24'd0, bus.product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, bus.done}, 32'd0);
    end
    do_op(4'h2, 4'hD, 8'hFA, 1'b0, "post_rst_2xm3");

    // Operands that change while busy do not affect the result (-5 * 6).
    do_op(4'hB, 4'h6, 8'hE2, 1'b1, "stable_m5x6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
